// File: rtl/osd_dem_uart_charbuf.sv
// Character buffer between the CPU-side TX/RX ports and the DEM-UART character handshakes.
// Both paths are first-word fall-through FIFOs; TX writes can be discarded while the debug network stalls.
module osd_dem_uart_charbuf #(
    parameter int TX_DEPTH      = 16,
    parameter int RX_DEPTH      = 16,
    parameter bit DROP_ON_STALL = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                cpu_tx_char,
    input  logic                      cpu_tx_valid,
    output logic                      cpu_tx_ready,
    output logic [7:0]                cpu_rx_char,
    output logic                      cpu_rx_valid,
    input  logic                      cpu_rx_ready,
    output logic [7:0]                dem_out_char,
    output logic                      dem_out_valid,
    input  logic                      dem_out_ready,
    input  logic [7:0]                dem_in_char,
    input  logic                      dem_in_valid,
    output logic                      dem_in_ready,
    input  logic                      dem_drop,
    input  logic                      tx_flush,
    output logic [$clog2(TX_DEPTH):0] tx_level,
    output logic [$clog2(RX_DEPTH):0] rx_level,
    output logic [15:0]               tx_drop_cnt
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_LVL = (TX_AW+1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_LVL = (RX_AW+1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_ONE      = (TX_AW+1)'(1);
    localparam logic [RX_AW:0] RX_ONE      = (RX_AW+1)'(1);

    logic [7:0]     r_tx_mem [TX_DEPTH];
    logic [TX_AW:0] r_tx_wptr;
    logic [TX_AW:0] r_tx_rptr;
    logic [7:0]     r_rx_mem [RX_DEPTH];
    logic [RX_AW:0] r_rx_wptr;
    logic [RX_AW:0] r_rx_rptr;
    logic [15:0]    r_drop_cnt;

    logic [TX_AW:0] w_tx_level;
    logic [RX_AW:0] w_rx_level;
    logic           w_tx_full;
    logic           w_tx_empty;
    logic           w_rx_full;
    logic           w_rx_empty;
    logic           w_drop_mode;
    logic           w_tx_accept;
    logic           w_tx_push;
    logic           w_tx_drop;
    logic           w_tx_pop;
    logic           w_rx_push;
    logic           w_rx_pop;

    // Pointers carry one extra MSB so a full FIFO is distinguishable from an empty one.
    assign w_tx_level  = r_tx_wptr - r_tx_rptr;
    assign w_rx_level  = r_rx_wptr - r_rx_rptr;
    assign w_tx_full   = (w_tx_level == TX_FULL_LVL);
    assign w_tx_empty  = (w_tx_level == '0);
    assign w_rx_full   = (w_rx_level == RX_FULL_LVL);
    assign w_rx_empty  = (w_rx_level == '0);

    // In drop mode the CPU is never stalled: writes are accepted and thrown away.
    assign w_drop_mode  = DROP_ON_STALL & dem_drop;
    assign cpu_tx_ready = !rst && !tx_flush && (!w_tx_full || w_drop_mode);
    assign w_tx_accept  = cpu_tx_valid && cpu_tx_ready;
    assign w_tx_push    = w_tx_accept && !w_drop_mode;
    assign w_tx_drop    = w_tx_accept && w_drop_mode;

    assign dem_out_valid = !rst && !w_tx_empty;
    assign dem_out_char  = r_tx_mem[r_tx_rptr[TX_AW-1:0]];
    assign w_tx_pop      = dem_out_valid && dem_out_ready;

    assign dem_in_ready = !rst && !w_rx_full;
    assign w_rx_push    = dem_in_valid && dem_in_ready;
    assign cpu_rx_valid = !rst && !w_rx_empty;
    assign cpu_rx_char  = r_rx_mem[r_rx_rptr[RX_AW-1:0]];
    assign w_rx_pop     = cpu_rx_valid && cpu_rx_ready;

    assign tx_level    = rst ? '0 : w_tx_level;
    assign rx_level    = rst ? '0 : w_rx_level;
    assign tx_drop_cnt = rst ? '0 : r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + TX_ONE;
            end
            // A flush swallows any pop presented in the same cycle.
            if (tx_flush) begin
                r_tx_rptr <= r_tx_wptr;
            end else if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + TX_ONE;
            end
            if (w_tx_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr[TX_AW-1:0]] <= cpu_tx_char;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + RX_ONE;
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + RX_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr[RX_AW-1:0]] <= dem_in_char;
        end
    end

endmodule

// File: tb/tb_osd_dem_uart_charbuf.sv
// Scoreboard bench for osd_dem_uart_charbuf: queues model both FIFOs, a negedge monitor checks every cycle.
module tb_osd_dem_uart_charbuf;
    localparam int TXD = 16;
    localparam int RXD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cpu_tx_char;
    logic       cpu_tx_valid;
    logic       cpu_tx_ready;
    logic [7:0] cpu_rx_char;
    logic       cpu_rx_valid;
    logic       cpu_rx_ready;
    logic [7:0] dem_out_char;
    logic       dem_out_valid;
    logic       dem_out_ready;
    logic [7:0] dem_in_char;
    logic       dem_in_valid;
    logic       dem_in_ready;
    logic       dem_drop;
    logic       tx_flush;
    logic [4:0] tx_level;
    logic [4:0] rx_level;
    logic [15:0] tx_drop_cnt;

    osd_dem_uart_charbuf #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DROP_ON_STALL(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cpu_tx_char(cpu_tx_char), .cpu_tx_valid(cpu_tx_valid), .cpu_tx_ready(cpu_tx_ready),
        .cpu_rx_char(cpu_rx_char), .cpu_rx_valid(cpu_rx_valid), .cpu_rx_ready(cpu_rx_ready),
        .dem_out_char(dem_out_char), .dem_out_valid(dem_out_valid), .dem_out_ready(dem_out_ready),
        .dem_in_char(dem_in_char), .dem_in_valid(dem_in_valid), .dem_in_ready(dem_in_ready),
        .dem_drop(dem_drop), .tx_flush(tx_flush),
        .tx_level(tx_level), .rx_level(rx_level), .tx_drop_cnt(tx_drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: plain queues of characters plus a saturating drop counter.
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int         m_drop = 0;
    bit         exp_tx_ready;
    bit         exp_in_ready;
    bit         tx_acc;
    int         n_vec = 0;
    int         n_err = 0;
    int         n_tx_pops = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: checks handshake/levels against the model, pops on every DUT transfer.
    always @(negedge clk) begin
        logic [7:0] e;
        exp_tx_ready = !rst && !tx_flush && ((tx_q.size() < TXD) || dem_drop);
        exp_in_ready = !rst && (rx_q.size() < RXD);
        chk("cpu_tx_ready", int'(cpu_tx_ready), int'(exp_tx_ready));
        chk("dem_in_ready", int'(dem_in_ready), int'(exp_in_ready));
        chk("dem_out_valid", int'(dem_out_valid), int'(!rst && tx_q.size() > 0));
        chk("cpu_rx_valid", int'(cpu_rx_valid), int'(!rst && rx_q.size() > 0));
        chk("tx_level", int'(tx_level), rst ? 0 : tx_q.size());
        chk("rx_level", int'(rx_level), rst ? 0 : rx_q.size());
        chk("tx_drop_cnt", int'(tx_drop_cnt), rst ? 0 : m_drop);
        if (dem_out_valid && dem_out_ready && tx_q.size() > 0) begin
            e = tx_q.pop_front();
            n_tx_pops++;
            chk("dem_out_char", int'(dem_out_char), int'(e));
        end
        if (cpu_rx_valid && cpu_rx_ready && rx_q.size() > 0) begin
            e = rx_q.pop_front();
            chk("cpu_rx_char", int'(cpu_rx_char), int'(e));
        end
    end

    // One clock: account the inputs held this cycle into the model, then return at posedge+1.
    task automatic step();
        @(negedge clk);
        #1;
        tx_acc = 1'b0;
        if (rst) begin
            tx_q.delete();
            rx_q.delete();
            m_drop = 0;
        end else begin
            if (cpu_tx_valid && exp_tx_ready) begin
                if (dem_drop) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    tx_q.push_back(cpu_tx_char);
                    tx_acc = 1'b1;
                end
            end
            if (tx_flush) tx_q.delete();
            if (dem_in_valid && exp_in_ready) rx_q.push_back(dem_in_char);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cpu_tx_valid = 1'b0;
        dem_in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int pops0;
        rst = 1'b1; cpu_tx_char = 8'h00; cpu_tx_valid = 1'b0; cpu_rx_ready = 1'b0;
        dem_out_ready = 1'b0; dem_in_char = 8'h00; dem_in_valid = 1'b0;
        dem_drop = 1'b0; tx_flush = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        step();

        // 'A','B','C' back to back through an open DEM port
        dem_out_ready = 1'b1;
        cpu_tx_valid = 1'b1;
        cpu_tx_char = 8'h41; step();
        cpu_tx_char = 8'h42; step();
        cpu_tx_char = 8'h43; step();
        idle(5);
        #1 chk("abc_drained", int'(tx_level), 0);

        // Fill 16 with the DEM port stalled; the 17th waits until draining starts
        dem_out_ready = 1'b0;
        for (int i = 0; i < TXD; i++) begin
            cpu_tx_valid = 1'b1;
            cpu_tx_char = 8'(8'h30 + i);
            step();
        end
        cpu_tx_char = 8'h77;
        for (int i = 0; i < 3; i++) begin
            #1 chk("fill_ready_low", int'(cpu_tx_ready), 0);
            chk("fill_level", int'(tx_level), TXD);
            step();
        end
        dem_out_ready = 1'b1;
        for (int i = 0; i < 5 && !tx_acc; i++) step();
        if (!tx_acc) chk("fill_17th_accept", 0, 1);
        idle(20);

        // Drop mode with 3 chars parked
        dem_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_tx_valid = 1'b1;
            cpu_tx_char = 8'(8'hA0 + i);
            step();
        end
        dem_drop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_tx_char = 8'($urandom);
            step();
        end
        dem_drop = 1'b0;
        cpu_tx_valid = 1'b0;
        #1 chk("drop_cnt5", int'(tx_drop_cnt), 5);
        chk("drop_level3", int'(tx_level), 3);
        dem_out_ready = 1'b1;
        idle(6);

        // Drop counter saturation
        dem_drop = 1'b1;
        cpu_tx_valid = 1'b1;
        for (int i = 0; i < 65532; i++) step();
        cpu_tx_valid = 1'b0;
        dem_drop = 1'b0;
        #1 chk("drop_sat", int'(tx_drop_cnt), 16'hFFFF);

        // Flush with 7 held and a concurrent pop
        dem_out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cpu_tx_valid = 1'b1;
            cpu_tx_char = 8'(8'h60 + i);
            step();
        end
        cpu_tx_valid = 1'b0;
        dem_out_ready = 1'b1;
        tx_flush = 1'b1;
        step();
        tx_flush = 1'b0;
        #1 chk("flush_level", int'(tx_level), 0);
        chk("flush_valid", int'(dem_out_valid), 0);
        pops0 = n_tx_pops;
        cpu_tx_valid = 1'b1;
        cpu_tx_char = 8'h5A;
        step();
        idle(4);
        chk("flush_sole_out", n_tx_pops - pops0, 1);

        // RX fill, then concurrent push/pop, then reset mid-stream
        cpu_rx_ready = 1'b0;
        for (int i = 0; i < RXD; i++) begin
            dem_in_valid = 1'b1;
            dem_in_char = 8'(i);
            step();
        end
        dem_in_char = 8'h99;
        #1 chk("rx_full_ready", int'(dem_in_ready), 0);
        step();
        cpu_rx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dem_in_char = 8'($urandom);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1 chk("rst_rx_level", int'(rx_level), 0);
        chk("rst_rx_valid", int'(cpu_rx_valid), 0);
        idle(2);

        // Randomized traffic on both paths
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 499) == 0);
            tx_flush      = ($urandom_range(0, 63) == 0);
            dem_drop      = ($urandom_range(0, 9) == 0);
            cpu_tx_valid  = $urandom_range(0, 1);
            cpu_tx_char   = 8'($urandom);
            dem_out_ready = ($urandom_range(0, 9) < 6);
            dem_in_valid  = $urandom_range(0, 1);
            dem_in_char   = 8'($urandom);
            cpu_rx_ready  = ($urandom_range(0, 9) < 5);
            step();
        end
        rst = 1'b0; tx_flush = 1'b0; dem_drop = 1'b0;
        dem_out_ready = 1'b1; cpu_rx_ready = 1'b1;
        idle(40);
        #1 chk("end_tx_level", int'(tx_level), 0);
        chk("end_rx_level", int'(rx_level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
